// File: rtl/vram_swap_ctrl_if.sv
// Signal bundle between vram_swap_ctrl and its neighbours: CPU register
// strobes, PPU vblank timing, VRAM buffer swap and vram_sync_writer handshake.
// The master side drives the request/timing strobes; the slave side is the
// swap controller itself.
interface vram_swap_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             swap_req;
    logic             vblank_start;
    logic             sync_done;
    logic             err_clr;
    logic             swap;
    logic             sync;
    logic             cpu_busy;
    logic             swap_pending;
    logic             swap_done;
    logic             err;
    logic [CNT_W-1:0] swap_count;

    modport master (
        output swap_req, vblank_start, sync_done, err_clr,
        input  swap, sync, cpu_busy, swap_pending, swap_done, err, swap_count
    );

    modport slave (
        input  swap_req, vblank_start, sync_done, err_clr,
        output swap, sync, cpu_busy, swap_pending, swap_done, err, swap_count
    );
endinterface

// File: rtl/vram_swap_ctrl.sv
// Double-buffered VRAM frame swap sequencer.
// A CPU swap request is latched and held until the next PPU vblank start.
// The controller then pulses the buffer-pair swap, launches vram_sync_writer
// with a one-cycle sync strobe and stalls CPU VRAM writes until the writer
// reports done. Requests arriving mid-swap are queued and re-arm on exit.
// Optional feature: define VRAM_SWAP_CTRL_TIMEOUT_EN to compile in the WAIT
// timeout counter and the sticky err flag; otherwise err is tied low.
module vram_swap_ctrl #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 8
) (
    input logic             clk,
    input logic             rst,
    vram_swap_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        SWAP,
        SYNC,
        WAIT
    } state_t;

    state_t           state;
    logic             req_q;
    logic             swap_q;
    logic             sync_q;
    logic             busy_q;
    logic             pending_q;
    logic             done_q;
    logic [CNT_W-1:0] count_q;

    // A request seen while the copy finishes (queued or same-cycle) re-arms.
    logic             rearm;
    assign rearm = req_q | bus.swap_req;

`ifdef VRAM_SWAP_CTRL_TIMEOUT_EN
    localparam int              TMR_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [TMR_W-1:0] tmr_q;
    logic             err_q;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    logic          unused_err_clr;
    assign unused_err_clr = bus.err_clr;
`endif

    // Swap sequencer: state and every output register advance together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            req_q     <= 1'b0;
            swap_q    <= 1'b0;
            sync_q    <= 1'b0;
            busy_q    <= 1'b0;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
            count_q   <= '0;
`ifdef VRAM_SWAP_CTRL_TIMEOUT_EN
            tmr_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments make every register here see the
            // same pre-edge values, so later assignments in this block only
            // override earlier defaults instead of chaining through them.
            swap_q <= 1'b0;
            sync_q <= 1'b0;
            done_q <= 1'b0;
`ifdef VRAM_SWAP_CTRL_TIMEOUT_EN
            // A timeout in the same cycle sets err again further down.
            if (bus.err_clr) err_q <= 1'b0;
            if (state == WAIT) tmr_q <= tmr_q + 1'b1;
`endif
            unique case (state)
                IDLE: begin
                    // vblank_start is ignored until a request is latched.
                    if (bus.swap_req) begin
                        state     <= ARMED;
                        pending_q <= 1'b1;
                    end
                end
                ARMED: begin
                    // Further requests are absorbed here.
                    if (bus.vblank_start) begin
                        state     <= SWAP;
                        swap_q    <= 1'b1;
                        busy_q    <= 1'b1;
                        pending_q <= 1'b0;
                    end
                end
                SWAP: begin
                    state  <= SYNC;
                    sync_q <= 1'b1;
                    if (bus.swap_req) begin
                        req_q     <= 1'b1;
                        pending_q <= 1'b1;
                    end
                end
                SYNC: begin
                    state <= WAIT;
`ifdef VRAM_SWAP_CTRL_TIMEOUT_EN
                    tmr_q <= '0;
`endif
                    if (bus.swap_req) begin
                        req_q     <= 1'b1;
                        pending_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (bus.sync_done) begin
                        state     <= rearm ? ARMED : IDLE;
                        pending_q <= rearm;
                        req_q     <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        count_q   <= count_q + 1'b1;
                    end
`ifdef VRAM_SWAP_CTRL_TIMEOUT_EN
                    else if (tmr_q == TMR_LAST) begin
                        state     <= rearm ? ARMED : IDLE;
                        pending_q <= rearm;
                        req_q     <= 1'b0;
                        busy_q    <= 1'b0;
                        err_q     <= 1'b1;
                    end
`endif
                    else if (bus.swap_req) begin
                        req_q     <= 1'b1;
                        pending_q <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_q     <= 1'b0;
                    busy_q    <= 1'b0;
                    pending_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.swap         = swap_q;
    assign bus.sync         = sync_q;
    assign bus.cpu_busy     = busy_q;
    assign bus.swap_pending = pending_q;
    assign bus.swap_done    = done_q;
    assign bus.swap_count   = count_q;
`ifdef VRAM_SWAP_CTRL_TIMEOUT_EN
    assign bus.err          = err_q;
`else
    assign bus.err          = 1'b0;
`endif

endmodule

// File: tb/tb_vram_swap_ctrl.sv
// Self-checking bench for vram_swap_ctrl. Pulse outputs (swap, sync,
// swap_done) are matched against a queue of expected events; level outputs
// are compared directly after each stimulus step. A second instance with a
// short timeout covers the optional VRAM_SWAP_CTRL_TIMEOUT_EN behaviour.
module tb_vram_swap_ctrl;

    localparam int CNT_W     = 8;
    localparam int TO_CYCLES = 16;

    typedef enum int {EV_SWAP, EV_SYNC, EV_DONE} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       cyc;
        int       count;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc;
    int   checks       = 0;
    int   failures     = 0;
    int   to_done_seen = 0;
    ev_t  exp_q[$];

    vram_swap_ctrl_if #(.CNT_W(CNT_W)) bus ();
    vram_swap_ctrl_if #(.CNT_W(CNT_W)) tbus ();

    vram_swap_ctrl #(.TIMEOUT_CYCLES(4096), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    vram_swap_ctrl #(.TIMEOUT_CYCLES(TO_CYCLES), .CNT_W(CNT_W)) dut_to (
        .clk(clk), .rst(rst), .bus(tbus)
    );

    always #10 clk = ~clk;

    // Cycle index: 0 in the first cycle after reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input ev_kind_t kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_%s: pulse at cycle %0d, expected none", kind.name(), cyc);
        end else begin
            e = exp_q.pop_front();
            check("ev_kind", kind, e.kind);
            check("ev_cycle", cyc, e.cyc);
            if (kind == EV_DONE) check("ev_done_count", bus.swap_count, e.count);
        end
    endtask

    // Monitor: every pulse from the main instance must match the next expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.swap === 1'b1)       expect_ev(EV_SWAP);
            if (bus.sync === 1'b1)       expect_ev(EV_SYNC);
            if (bus.swap_done === 1'b1)  expect_ev(EV_DONE);
            if (tbus.swap_done === 1'b1) to_done_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic pulse_req();  bus.swap_req = 1'b1;     tick(); bus.swap_req = 1'b0;     endtask
    task automatic pulse_vbl();  bus.vblank_start = 1'b1; tick(); bus.vblank_start = 1'b0; endtask
    task automatic pulse_done(); bus.sync_done = 1'b1;    tick(); bus.sync_done = 1'b0;    endtask

    task automatic t_req();  tbus.swap_req = 1'b1;     tick(); tbus.swap_req = 1'b0;     endtask
    task automatic t_vbl();  tbus.vblank_start = 1'b1; tick(); tbus.vblank_start = 1'b0; endtask
    task automatic t_done(); tbus.sync_done = 1'b1;    tick(); tbus.sync_done = 1'b0;    endtask
    task automatic t_clr();  tbus.err_clr = 1'b1;      tick(); tbus.err_clr = 1'b0;      endtask

    // vblank accepted in cycle c: swap in c+1, sync in c+2.
    task automatic expect_swap_at(input int c);
        exp_q.push_back('{EV_SWAP, c + 1, 0});
        exp_q.push_back('{EV_SYNC, c + 2, 0});
    endtask

    // Watchdog: the bench never needs anywhere near this long.
    initial begin
        #(20 * 40000);
        $display("FAIL watchdog: simulation exceeded 40000 cycles");
        $fatal(1);
    end

    initial begin
        int c;
        int s;
        bus.swap_req = 1'b0;  bus.vblank_start = 1'b0;  bus.sync_done = 1'b0;  bus.err_clr = 1'b0;
        tbus.swap_req = 1'b0; tbus.vblank_start = 1'b0; tbus.sync_done = 1'b0; tbus.err_clr = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        check("reset_flags", {bus.swap, bus.sync, bus.cpu_busy, bus.swap_pending, bus.swap_done, bus.err}, 0);
        check("reset_count", bus.swap_count, 0);

        // Nominal swap: request at 5, vblank at 20, writer done at 2074.
        wait_to(5);
        pulse_req();
        check("req_pending", bus.swap_pending, 1);
        check("req_not_busy", bus.cpu_busy, 0);
        wait_to(20);
        expect_swap_at(20);
        pulse_vbl();
        check("swap_busy", bus.cpu_busy, 1);
        check("swap_pending_clr", bus.swap_pending, 0);
        wait_to(2074);
        check("wait_busy", bus.cpu_busy, 1);
        exp_q.push_back('{EV_DONE, 2075, 1});
        pulse_done();
        check("done_busy_clr", bus.cpu_busy, 0);
        check("done_count1", bus.swap_count, 1);

        // vblank without a request does nothing.
        repeat (3) tick();
        pulse_vbl();
        repeat (4) tick();
        check("vbl_only_busy", bus.cpu_busy, 0);
        check("vbl_only_pending", bus.swap_pending, 0);

        // Same-cycle request and vblank: arm only, swap at the next vblank.
        bus.swap_req = 1'b1;
        bus.vblank_start = 1'b1;
        tick();
        bus.swap_req = 1'b0;
        bus.vblank_start = 1'b0;
        check("same_cycle_pending", bus.swap_pending, 1);
        repeat (6) tick();
        check("same_cycle_armed", bus.swap_pending, 1);
        check("same_cycle_no_busy", bus.cpu_busy, 0);
        pulse_done();                    // stray writer done outside WAIT
        repeat (3) tick();
        c = cyc;
        expect_swap_at(c);
        pulse_vbl();
        tick();
        tick();                          // first WAIT cycle
        pulse_req();                     // queued request during WAIT
        check("wait_req_pending", bus.swap_pending, 1);
        check("wait_req_busy", bus.cpu_busy, 1);
        pulse_vbl();                     // vblank during WAIT is ignored
        repeat (10) tick();
        exp_q.push_back('{EV_DONE, cyc + 1, 2});
        pulse_done();
        check("requeue_pending", bus.swap_pending, 1);
        check("requeue_busy", bus.cpu_busy, 0);
        check("done_count2", bus.swap_count, 2);

        // Queued request swaps at the next vblank with minimum latency.
        repeat (3) tick();
        c = cyc;
        expect_swap_at(c);
        pulse_vbl();
        tick();
        tick();
        exp_q.push_back('{EV_DONE, c + 4, 3});
        pulse_done();
        check("min_lat_busy", bus.cpu_busy, 0);
        check("min_lat_pending", bus.swap_pending, 0);
        check("done_count3", bus.swap_count, 3);

        // Reset 100 cycles into WAIT abandons the copy immediately.
        repeat (2) tick();
        pulse_req();
        c = cyc;
        expect_swap_at(c);
        pulse_vbl();
        wait_to(c + 103);
        check("wait100_busy", bus.cpu_busy, 1);
        rst = 1'b1;
        #1;
        check("rst_mid_flags", {bus.swap, bus.sync, bus.cpu_busy, bus.swap_pending, bus.swap_done, bus.err}, 0);
        check("rst_mid_count", bus.swap_count, 0);
        tick();
        rst = 1'b0;
        pulse_done();                    // late writer done after reset
        repeat (3) tick();
        check("late_done_busy", bus.cpu_busy, 0);
        check("late_done_count", bus.swap_count, 0);

        // 256 minimum-latency swaps: counter wraps back to 0.
        for (int i = 0; i < 256; i++) begin
            pulse_req();
            c = cyc;
            expect_swap_at(c);
            pulse_vbl();
            tick();
            tick();
            exp_q.push_back('{EV_DONE, cyc + 1, (i + 1) % 256});
            pulse_done();
        end
        check("wrap_count", bus.swap_count, 0);
        check("wrap_pending", bus.swap_pending, 0);

        // Short-timeout instance: no writer done after sync.
        t_req();
        c = cyc;
        t_vbl();
        s = c + 2;
        wait_to(s + TO_CYCLES);
        check("to_last_wait_busy", tbus.cpu_busy, 1);
        check("to_last_wait_err", tbus.err, 0);
        tick();
`ifdef VRAM_SWAP_CTRL_TIMEOUT_EN
        check("to_exit_busy", tbus.cpu_busy, 0);
        check("to_err_set", tbus.err, 1);
        check("to_pending", tbus.swap_pending, 0);
        repeat (3) tick();
        check("to_err_sticky", tbus.err, 1);
        t_clr();
        check("to_err_clr", tbus.err, 0);
        // err_clr in the timeout cycle: set wins.
        t_req();
        c = cyc;
        t_vbl();
        s = c + 2;
        wait_to(s + TO_CYCLES);
        t_clr();
        check("to_set_wins", tbus.err, 1);
        check("to_set_wins_busy", tbus.cpu_busy, 0);
        repeat (2) tick();
        check("to_no_done", to_done_seen, 0);
`else
        check("nto_still_busy", tbus.cpu_busy, 1);
        check("nto_err_low", tbus.err, 0);
        t_clr();
        check("nto_clr_err_low", tbus.err, 0);
        t_done();
        check("nto_done_busy", tbus.cpu_busy, 0);
        tick();
        check("nto_done_seen", to_done_seen, 1);
        check("nto_count", tbus.swap_count, 1);
`endif

        repeat (3) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vram_swap_ctrl.md
# vram_swap_ctrl

Sequences the double-buffered VRAM frame swap. Latches a CPU swap request and waits for the PPU's vblank start. It then pulses the VRAM `swap` input, launches `vram_sync_writer` with a one-cycle `sync` pulse, and stalls CPU VRAM writes until the writer reports `done`. It sits between the CPU register interface, the PPU timing generator, the VRAM buffer pair and `vram_sync_writer`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 4096: maximum WAIT cycles before the copy is declared failed. The nominal copy is about 2052 cycles.
- `CNT_W`, 8: width of the completed-swap counter.

Ports:
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  reset, asynchronous, active-high.
- `swap_req`  in  1  one-cycle pulse from the CPU register write.
- `vblank_start`  in  1  one-cycle pulse from the PPU at the first vblank line.
- `sync_done`  in  1  one-cycle pulse from `vram_sync_writer.done`.
- `err_clr`  in  1  one-cycle pulse that clears `err`.
- `swap`  out  1  one-cycle pulse to the VRAM buffer pair.
- `sync`  out  1  one-cycle pulse to `vram_sync_writer.sync`.
- `cpu_busy`  out  1  CPU VRAM writes must stall while high.
- `swap_pending`  out  1  a request is latched and waiting for vblank.
- `swap_done`  out  1  one-cycle pulse when a copy completes.
- `err`  out  1  sticky flag: a copy timed out.
- `swap_count`  out  CNT_W  number of completed swaps, wrapping.

## Operation
- States: IDLE, ARMED, SWAP, SYNC, WAIT. All outputs are registered or decoded from the state register; there are no combinational paths from inputs to outputs.
- IDLE:
  - `swap_req` → ARMED.
  - `vblank_start` is ignored.
- ARMED:
  - `swap_pending`=1.
  - `vblank_start` → SWAP.
  - A further `swap_req` is absorbed, with no effect.
- SWAP: `swap`=1 and `cpu_busy`=1 for exactly one cycle, then → SYNC.
- SYNC: `sync`=1 and `cpu_busy`=1 for exactly one cycle; the timeout counter is cleared to 0; then → WAIT.
- WAIT:
  - `cpu_busy`=1; the timeout counter increments by 1 per cycle.
  - `sync_done` → IDLE; pulse `swap_done`; `swap_count` += 1 (wraps 2^CNT_W−1 → 0).
  - Counter reaches `TIMEOUT_CYCLES`−1 without `sync_done` → IDLE; set `err`; no `swap_done`; `swap_count` unchanged.
- Request during SWAP, SYNC or WAIT:
  - It sets an internal `req_q` flag.
  - On exit to IDLE with `req_q`=1, the next state is ARMED (not IDLE) and `req_q` clears.
  - `swap_pending` = (state==ARMED) | `req_q`.
- `vblank_start` during SWAP, SYNC or WAIT is ignored; it never triggers a second swap in the same frame.
- `err`:
  - Sticky; cleared only by `err_clr` or `rst`.
  - If `err_clr` and a timeout occur in the same cycle, the set wins.
- `sync_done` outside WAIT is ignored.

## Timing
- Reset values: state=IDLE, `req_q`=0, `swap`=0, `sync`=0, `cpu_busy`=0, `swap_pending`=0, `swap_done`=0, `err`=0, `swap_count`=0.
- Asserting `rst` mid-operation, including in WAIT, returns immediately to these values. The in-flight copy is abandoned; the writer is not notified.
- `swap_req` sampled at edge N in IDLE → `swap_pending`=1 from cycle N+1.
- Same-cycle `swap_req` and `vblank_start` in IDLE → ARMED. The vblank is not consumed, and the swap occurs at the next vblank.
- `vblank_start` sampled at edge N in ARMED:
  - `swap`=1 in cycle N+1.
  - `sync`=1 in cycle N+2.
  - `cpu_busy` high from N+1 through the cycle in which `sync_done` is sampled.
- `sync_done` sampled at edge M:
  - `swap_done`=1 and `cpu_busy`=0 in cycle M+1.
  - `swap_count` updated in M+1.
- Minimum `swap` to `swap_done` is 3 cycles, when `sync_done` arrives in the first WAIT cycle.

## Configuration
- `VRAM_SWAP_CTRL_TIMEOUT_EN` defined: the WAIT timeout counter and `err` logic are compiled in, as described above.
- Undefined: no counter; WAIT exits only on `sync_done` or `rst`; `err` is tied to 0; `err_clr` is ignored; `TIMEOUT_CYCLES` is unused.

## Test plan
- Reset, then `swap_req` at cycle 5 and `vblank_start` at cycle 20 → `swap` at 21, `sync` at 22, `cpu_busy` high 21..; `sync_done` at 2074 → `swap_done` at 2075, `swap_count`=1, `cpu_busy`=0 at 2075.
- `vblank_start` with no request → no `swap` or `sync`, `cpu_busy` stays 0. Same-cycle `swap_req`+`vblank_start` → swap only at the following vblank.
- `swap_req` during WAIT → after `swap_done`, `swap_pending`=1; next `vblank_start` → second swap; `swap_count`=2.
- With `VRAM_SWAP_CTRL_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16, no `sync_done` → return to IDLE 16 cycles after `sync`; `err`=1; `swap_done` never asserts. `err_clr` → `err`=0.
- Assert `rst` 100 cycles into WAIT → all outputs 0 immediately. A late `sync_done` → no `swap_done`.
- 256 completed swaps with `CNT_W`=8 → `swap_count` wraps to 0.
